oled_link_arbiter: RTL and testbench

- Shares the single OLED serial link (nCS, DnC, SDIN, SCLK) between up to four byte-stream requesters, e.g. the software command path, the auto block-refresh engine and a power-up init sequencer.
- Arbitrates round-robin per burst. A granted requester keeps the link until it sends a byte flagged last.
- Serialises each byte MSB-first, 2 HCLK per bit: SCLK low phase, then SCLK high phase.

---
 rtl/oled_link_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_oled_link_arbiter.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_link_arbiter.sv
// oled_link_arbiter: round-robin burst arbiter sharing one OLED serial link
// between NUM_REQ byte-stream requesters, with MSB-first 2-cycle/bit shifter.
// Ports: HCLK, HRESET (async, active-high); req_valid/req_data/req_dnc/
// req_last in, req_ready/grant out; busy, timeout_pulse; nCS, DnC, SDIN, SCLK.
// Optional: define OLED_ARB_TIMEOUT_EN to drop an owner stalled TIMEOUT cycles.
module oled_link_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CS_GAP  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_dnc,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse,
  output logic                 nCS,
  output logic                 DnC,
  output logic                 SDIN,
  output logic                 SCLK
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_END,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]      rr_q, rr_d;
  logic [PW-1:0]      own_q, own_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               dnc_q, dnc_d;
  logic               last_q, last_d;
  logic [2:0]         bit_q, bit_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_REQ-1:0] ready_c;
  logic [PW-1:0]      nxt_rr;

  logic [PW-1:0] win;
  logic          win_vld;
  logic [7:0]    win_data;
  logic          win_dnc;
  logic          win_last;
  logic [7:0]    own_data;
  logic          own_dnc;
  logic          own_last;
  logic          own_vld;
  int            idx;

`ifdef OLED_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_END = SW'(TIMEOUT - 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          tmo_c;
`endif

  // Scan downwards so the lowest offset from the pointer wins last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && req_valid[i]) begin
          win     = PW'(i);
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_dnc  = 1'b0;
    win_last = 1'b0;
    own_data = '0;
    own_dnc  = 1'b0;
    own_last = 1'b0;
    own_vld  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        win_data = req_data[8*i +: 8];
        win_dnc  = req_dnc[i];
        win_last = req_last[i];
      end
      if (own_q == PW'(i)) begin
        own_data = req_data[8*i +: 8];
        own_dnc  = req_dnc[i];
        own_last = req_last[i];
        own_vld  = req_valid[i];
      end
    end
  end

  assign nxt_rr = (own_q == LAST_IDX) ? '0 : own_q + PW'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    grant_d = grant_q;
    shreg_d = shreg_q;
    dnc_d   = dnc_q;
    last_d  = last_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    ready_c = '0;
`ifdef OLED_ARB_TIMEOUT_EN
    stall_d = stall_q;
    tmo_c   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld && !HRESET) begin
          ready_c[win] = 1'b1;
          own_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          shreg_d      = win_data;
          dnc_d        = win_dnc;
          last_d       = win_last;
          bit_d        = '0;
          state_d      = S_LO;
        end
      end
      S_LO: begin
        state_d = S_HI;
      end
      S_HI: begin
        if (bit_q == 3'd7) begin
          state_d = S_END;
        end else begin
          shreg_d = {shreg_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          state_d = S_LO;
        end
      end
      S_END: begin
        if (last_q) begin
          grant_d = '0;
          rr_d    = nxt_rr;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (own_vld) begin
          ready_c[own_q] = 1'b1;
          shreg_d        = own_data;
          dnc_d          = own_dnc;
          last_d         = own_last;
          bit_d          = '0;
          state_d        = S_LO;
        end
`ifdef OLED_ARB_TIMEOUT_EN
        else if (stall_q == STALL_END) begin
          tmo_c   = 1'b1;
          grant_d = '0;
          rr_d    = nxt_rr;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      S_GAP: begin
        if (gap_q == GAP_END) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef OLED_ARB_TIMEOUT_EN
    if (ready_c != '0 || tmo_c) begin
      stall_d = '0;
    end
`endif
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      grant_q <= '0;
      shreg_q <= '0;
      dnc_q   <= 1'b0;
      last_q  <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      shreg_q <= shreg_d;
      dnc_q   <= dnc_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

`ifdef OLED_ARB_TIMEOUT_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign timeout_pulse = tmo_c;
`else
  assign timeout_pulse = 1'b0;
`endif

  // Link pins decode straight from state so reset drops them at once.
  logic link_on;
  assign link_on   = (state_q == S_LO) || (state_q == S_HI) ||
                     (state_q == S_END);
  assign nCS       = ~link_on;
  assign SCLK      = (state_q == S_HI);
  assign SDIN      = link_on & shreg_q[7];
  assign DnC       = dnc_q;
  assign busy      = (state_q != S_IDLE);
  assign grant     = grant_q;
  assign req_ready = ready_c;

endmodule

// File: tb/tb_oled_link_arbiter.sv
// tb_oled_link_arbiter: randomized and directed bench for oled_link_arbiter,
// decoding the serial link and comparing against a burst-level RR model.
module tb_oled_link_arbiter;

  localparam int N    = 3;
  localparam int GAPC = 2;
  localparam int TMO  = 16;

  logic           HCLK = 1'b0;
  logic           HRESET = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_dnc;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_pulse;
  logic           nCS;
  logic           DnC;
  logic           SDIN;
  logic           SCLK;

  always #5 HCLK = ~HCLK;

  oled_link_arbiter #(
    .NUM_REQ(N),
    .CS_GAP (GAPC),
    .TIMEOUT(TMO)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_dnc      (req_dnc),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .nCS          (nCS),
    .DnC          (DnC),
    .SDIN         (SDIN),
    .SCLK         (SCLK)
  );

  int nvec = 0;
  int nmis = 0;

  // Requester sources: {last, dnc, data}
  logic [9:0] src_mem [N][32];
  int         src_len [N];
  int         src_pos [N];
  bit         hold    [N];
  int         mrr;

  logic [10:0] exp_q[$];
  int          exp_b[$];
  logic [10:0] rx_q[$];
  int          bur_q[$];
  int          gap_q[$];
  int          lat_q[$];
  int          tmo_q[$];

  int         cyc = 0;
  int         low_run, gap_run, bitn, last_acc, last_rise;
  int         dnc_bad, rdy_bad;
  logic [7:0] rxb;
  logic       rxd;
  logic       prev_ncs, prev_sclk;

  task automatic mon_clear();
    rx_q.delete(); bur_q.delete(); gap_q.delete();
    lat_q.delete(); tmo_q.delete();
    low_run = 0; gap_run = 0; bitn = 0;
    dnc_bad = 0; rdy_bad = 0;
    last_acc = -100; last_rise = -100;
    rxb = '0; rxd = 1'b0;
    prev_ncs = 1'b1; prev_sclk = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && src_pos[i] < src_len[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
        req_dnc[i]        = src_mem[i][src_pos[i]][8];
        req_last[i]       = src_mem[i][src_pos[i]][9];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_dnc[i]        = 1'b0;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic src_clear();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      hold[i]    = 1'b0;
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d,
                          input logic dc, input logic l);
    src_mem[r][src_len[r]] = {l, dc, d};
    src_len[r]++;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    src_clear();
    drive();
    mrr = 0;
    exp_q.delete(); exp_b.delete();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    mon_clear();
    @(posedge HCLK); #1;
  endtask

  // One clock: monitor at negedge, advance sources after the edge.
  task automatic step();
    logic [N-1:0] acc;
    logic [1:0]   own;
    @(negedge HCLK);
    cyc++;
    if (!nCS) low_run++;
    else if (!prev_ncs) begin
      bur_q.push_back(low_run);
      low_run = 0;
    end
    if (nCS && busy) gap_run++;
    else if (gap_run > 0) begin
      gap_q.push_back(gap_run);
      gap_run = 0;
    end
    if (SCLK && !prev_sclk) begin
      if (bitn == 0) begin
        lat_q.push_back(cyc - last_acc);
        rxd = DnC;
      end else if (DnC !== rxd) dnc_bad++;
      rxb = {rxb[6:0], SDIN};
      bitn++;
      last_rise = cyc;
      if (bitn == 8) begin
        own = 2'd3;
        if ($countones(grant) == 1)
          for (int i = 0; i < N; i++) if (grant[i]) own = 2'(i);
        rx_q.push_back({own, rxd, rxb});
        bitn = 0;
      end
    end
    if (timeout_pulse) tmo_q.push_back(cyc - last_rise);
    if ($countones(req_ready) > 1) rdy_bad++;
    acc = req_valid & req_ready;
    if (acc != '0) last_acc = cyc;
    prev_ncs = nCS;
    prev_sclk = SCLK;
    @(posedge HCLK); #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
    drive();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) return 1'b0;
    return !busy;
  endfunction

  task automatic run_until_idle(input string nm, input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    nvec++;
    if (n >= budget) begin
      nmis++;
      $display("FAIL %s idle_wait: got %0d cycles, want < %0d", nm, n, budget);
    end
    repeat (2) step();
  endtask

  // Burst-level round robin: whole bursts pop from the first pending
  // requester at/after the pointer, pointer moves past the winner.
  task automatic model_expect();
    int p [N];
    int w, n, id;
    logic [9:0] e;
    for (int i = 0; i < N; i++) p[i] = src_pos[i];
    while (1) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        id = (mrr + k) % N;
        if (w < 0 && p[id] < src_len[id]) w = id;
      end
      if (w < 0) break;
      n = 0;
      do begin
        e = src_mem[w][p[w]];
        p[w]++;
        n++;
        exp_q.push_back({2'(w), e[8], e[7:0]});
      end while (!e[9] && p[w] < src_len[w]);
      exp_b.push_back(n);
      mrr = (w + 1) % N;
    end
  endtask

  task automatic check_results(input string nm, input bit chk_len);
    logic [10:0] got;
    nvec++;
    if (rx_q.size() != exp_q.size()) begin
      nmis++;
      $display("FAIL %s byte_count: got %0d want %0d",
               nm, rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (i < rx_q.size()) ? rx_q[i] : 11'h7ff;
      nvec++;
      if (got !== exp_q[i]) begin
        nmis++;
        $display("FAIL %s byte%0d: got req%0d dnc%0b %02h want req%0d dnc%0b %02h",
                 nm, i, got[10:9], got[8], got[7:0],
                 exp_q[i][10:9], exp_q[i][8], exp_q[i][7:0]);
      end
    end
    nvec++;
    if (gap_q.size() != exp_b.size()) begin
      nmis++;
      $display("FAIL %s gap_count: got %0d want %0d",
               nm, gap_q.size(), exp_b.size());
    end
    foreach (gap_q[i]) begin
      nvec++;
      if (gap_q[i] != GAPC) begin
        nmis++;
        $display("FAIL %s gap%0d: got %0d want %0d", nm, i, gap_q[i], GAPC);
      end
    end
    if (chk_len) begin
      nvec++;
      if (bur_q.size() != exp_b.size()) begin
        nmis++;
        $display("FAIL %s burst_count: got %0d want %0d",
                 nm, bur_q.size(), exp_b.size());
      end
      foreach (exp_b[i]) begin
        nvec++;
        if (i >= bur_q.size() || bur_q[i] != 17 * exp_b[i]) begin
          nmis++;
          $display("FAIL %s ncs_low%0d: got %0d want %0d", nm, i,
                   (i < bur_q.size()) ? bur_q[i] : -1, 17 * exp_b[i]);
        end
      end
    end
    foreach (lat_q[i]) begin
      nvec++;
      if (lat_q[i] != 2) begin
        nmis++;
        $display("FAIL %s first_rise%0d: got %0d want 2", nm, i, lat_q[i]);
      end
    end
    nvec++;
    if (dnc_bad != 0 || rdy_bad != 0) begin
      nmis++;
      $display("FAIL %s dnc_ready: got dnc_glitch=%0d multi_ready=%0d want 0 0",
               nm, dnc_bad, rdy_bad);
    end
    exp_q.delete();
    exp_b.delete();
    mon_clear();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    req_valid = '1;
    req_data = '1;
    req_dnc = '1;
    req_last = '1;
    @(negedge HCLK);
    nvec++;
    if ({nCS, SCLK, SDIN, DnC, busy, timeout_pulse} !== 6'b100000) begin
      nmis++;
      $display("FAIL reset_pins: got %b want 100000",
               {nCS, SCLK, SDIN, DnC, busy, timeout_pulse});
    end
    nvec++;
    if (grant !== '0) begin
      nmis++;
      $display("FAIL reset_grant: got %b want 0", grant);
    end
    nvec++;
    if (req_ready !== '0) begin
      nmis++;
      $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    do_reset();
    repeat (3) step();
    nvec++;
    if ({nCS, SCLK, busy} !== 3'b100 || grant !== '0) begin
      nmis++;
      $display("FAIL idle_after_reset: got nCS/SCLK/busy=%b grant=%b want 100 0",
               {nCS, SCLK, busy}, grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    add_byte(0, 8'hA5, 1'b0, 1'b1);
    model_expect();
    drive();
    run_until_idle("single", 200);
    check_results("single", 1'b1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    add_byte(0, 8'h11, 1'b1, 1'b1);
    add_byte(1, 8'h22, 1'b0, 1'b1);
    model_expect();
    drive();
    run_until_idle("simul1", 300);
    check_results("simul1", 1'b1);
    add_byte(0, 8'h33, 1'b0, 1'b1);
    add_byte(1, 8'h44, 1'b1, 1'b1);
    model_expect();
    drive();
    run_until_idle("simul2", 300);
    check_results("simul2", 1'b1);
  endtask

  task automatic test_burst_lock();
    do_reset();
    add_byte(0, 8'h15, 1'b1, 1'b0);
    add_byte(0, 8'h00, 1'b1, 1'b0);
    add_byte(0, 8'h07, 1'b1, 1'b1);
    add_byte(1, 8'h5A, 1'b0, 1'b1);
    model_expect();
    drive();
    run_until_idle("lock", 400);
    check_results("lock", 1'b1);
  endtask

  task automatic test_stall();
    int low, blk, n;
    do_reset();
    add_byte(0, 8'h81, 1'b1, 1'b0);
    add_byte(0, 8'h7E, 1'b1, 1'b1);
    add_byte(1, 8'hC6, 1'b0, 1'b1);
`ifdef OLED_ARB_TIMEOUT_EN
    exp_q.push_back({2'd0, 1'b1, 8'h81});
    exp_q.push_back({2'd1, 1'b0, 8'hC6});
    exp_q.push_back({2'd0, 1'b1, 8'h7E});
    exp_b.push_back(1); exp_b.push_back(1); exp_b.push_back(1);
    mrr = 1;
`else
    model_expect();
`endif
    drive();
    n = 0;
    while (src_pos[0] < 1 && n < 20) begin
      step();
      n++;
    end
    nvec++;
    if (src_pos[0] < 1) begin
      nmis++;
      $display("FAIL stall_first_accept: got 0 accepts want 1");
    end
    hold[0] = 1'b1;
    drive();
    low = 0;
    blk = 0;
    repeat (200) begin
      step();
      if (!nCS) low++;
      if (grant[1] || req_ready[1]) blk++;
    end
`ifdef OLED_ARB_TIMEOUT_EN
    nvec++;
    if (low != 48) begin
      nmis++;
      $display("FAIL stall_ncs_low: got %0d want 48", low);
    end
    nvec++;
    if (blk == 0) begin
      nmis++;
      $display("FAIL stall_req1_served: got 0 grant cycles want >0");
    end
    nvec++;
    if (tmo_q.size() != 1 || tmo_q[0] != TMO) begin
      nmis++;
      $display("FAIL stall_timeout: got %0d pulses at %0d want 1 at %0d",
               tmo_q.size(), (tmo_q.size() > 0) ? tmo_q[0] : -1, TMO);
    end
`else
    nvec++;
    if (low != 200) begin
      nmis++;
      $display("FAIL stall_ncs_low: got %0d want 200", low);
    end
    nvec++;
    if (blk != 0) begin
      nmis++;
      $display("FAIL stall_req1_blocked: got %0d grant cycles want 0", blk);
    end
    nvec++;
    if (tmo_q.size() != 0) begin
      nmis++;
      $display("FAIL stall_timeout: got %0d pulses want 0", tmo_q.size());
    end
`endif
    hold[0] = 1'b0;
    drive();
    run_until_idle("stall", 300);
    check_results("stall", 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    add_byte(0, 8'hC3, 1'b1, 1'b1);
    drive();
    n = 0;
    while (bitn < 3 && n < 40) begin
      step();
      n++;
    end
    @(posedge HCLK); #1;
    nvec++;
    if (SCLK !== 1'b1 || nCS !== 1'b0) begin
      nmis++;
      $display("FAIL mid_pre: got SCLK=%b nCS=%b want 1 0", SCLK, nCS);
    end
    HRESET = 1'b1;
    #1;
    nvec++;
    if (nCS !== 1'b1 || SCLK !== 1'b0) begin
      nmis++;
      $display("FAIL mid_async: got nCS=%b SCLK=%b want 1 0", nCS, SCLK);
    end
    do_reset();
    add_byte(1, 8'h3C, 1'b1, 1'b1);
    model_expect();
    drive();
    run_until_idle("mid_restart", 200);
    check_results("mid_restart", 1'b1);
  endtask

  task automatic test_random();
    int nb, len, tot;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      src_clear();
      tot = 0;
      for (int i = 0; i < N; i++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            add_byte(i, 8'($urandom), 1'($urandom), k == len - 1);
            tot++;
          end
        end
      end
      if (tot == 0) add_byte(r % N, 8'($urandom), 1'($urandom), 1'b1);
      model_expect();
      drive();
      run_until_idle("random", 3000);
      check_results("random", 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    src_clear();
    mon_clear();
    mrr = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_burst_lock();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
